reg_dump_ctrl: RTL and testbench

- Debug/readback engine that sits on the register bank's two asynchronous read ports (ra1/rd1, ra2/rd2) and streams a requested register range out over a valid/ready interface, one register per beat.
- Fetches two registers per access cycle, buffers them, then serialises them with their index.
- Asserts freeze while active so the core holds off register writes and the dump is a consistent snapshot.

---
 rtl/reg_dump_ctrl.sv | 124 ++++++++++++
 tb/tb_reg_dump_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_ctrl.sv
// Register-bank readback engine: fetches two registers per access through the
// bank's asynchronous read ports and streams them out one per valid/ready beat.
module reg_dump_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic              busy,
  output logic              freeze,
  output logic              done,
  output logic [ADDR_W-1:0] ra1,
  output logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND0,
    SEND1,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W-1:0] last, last_nxt;
  logic [ADDR_W-1:0] ptr_p1;
  logic [DATA_W-1:0] buf0, buf1;

  // Pointer arithmetic wraps modulo the bank size.
  assign ptr_p1 = ptr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      last  <= '0;
      buf0  <= '0;
      buf1  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      last  <= last_nxt;
      if (state == FETCH) begin
        buf0 <= rd1;
        buf1 <= rd2;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    last_nxt  = last;
    busy      = 1'b1;
    done      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    ra1       = ptr;
    ra2       = ptr_p1;

    case (state)
      IDLE: begin
        // Read addresses are parked at zero while idle so they match reset.
        busy = 1'b0;
        ra1  = '0;
        ra2  = '0;
        if (start) begin
          ptr_nxt   = first_reg;
          last_nxt  = last_reg;
          state_nxt = (first_reg <= last_reg) ? FETCH : DONE;
        end
      end
      FETCH: begin
        state_nxt = SEND0;
      end
      SEND0: begin
        out_valid = 1'b1;
        out_data  = buf0;
        out_idx   = ptr;
        out_last  = (ptr == last);
        if (out_ready) begin
          state_nxt = (ptr == last) ? DONE : SEND1;
        end
      end
      SEND1: begin
        out_valid = 1'b1;
        out_data  = buf1;
        out_idx   = ptr_p1;
        out_last  = (ptr_p1 == last);
        if (out_ready) begin
          if (ptr_p1 == last) begin
            state_nxt = DONE;
          end else begin
            ptr_nxt   = ptr + ADDR_W'(2);
            state_nxt = FETCH;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    freeze = busy;
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Scoreboard bench for reg_dump_ctrl: expected beats are queued at start and
// matched against every valid beat; each scenario task also checks timing.
module tb_reg_dump_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] first_reg, last_reg;
  logic              busy, freeze, done;
  logic [ADDR_W-1:0] ra1, ra2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;

  reg_dump_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .busy(busy), .freeze(freeze), .done(done), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] bank [0:31];
  assign rd1 = bank[ra1];
  assign rd2 = bank[ra2];

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t sbq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;
  logic [ADDR_W-1:0] ra1_log [0:299];
  logic [ADDR_W-1:0] ra2_log [0:299];

  always @(posedge clk) cyc++;

  // Every presented beat must match the head of the scoreboard, stalled or not.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_beat: got idx=%0d data=%h last=%b, expected no beat",
                 out_idx, out_data, out_last);
      end else if (out_idx !== sbq[0].idx || out_data !== sbq[0].data || out_last !== sbq[0].last) begin
        errors++;
        $display("[TB] FAIL beat: got idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                 out_idx, out_data, out_last, sbq[0].idx, sbq[0].data, sbq[0].last);
      end
      if (out_ready === 1'b1 && sbq.size() > 0) void'(sbq.pop_front());
    end
  end

  task automatic pulse_start(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    t_start   = cyc;
    for (int i = int'(f); i <= int'(l); i++) begin
      beat_t b;
      b.idx  = ADDR_W'(i);
      b.data = bank[i];
      b.last = (i == int'(l));
      sbq.push_back(b);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit stall, output int lat, output int freeze_bad, output int busy_cyc);
    logic pat [4];
    pat        = '{1'b1, 1'b0, 1'b0, 1'b1};
    lat        = -1;
    freeze_bad = 0;
    busy_cyc   = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ra1_log[i] = ra1;
      ra2_log[i] = ra2;
      if (freeze !== busy || busy !== 1'b1) freeze_bad++;
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin
        lat = cyc - t_start + 1;
        break;
      end
      @(posedge clk); #1;
      if (stall) begin
        out_ready = pat[i % 4];
        if (i == 3) begin
          start     = 1'b1;
          first_reg = 5'd20;
          last_reg  = 5'd25;
        end else begin
          start = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    start     = 1'b0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    start     = 1'b0;
    first_reg = '0;
    last_reg  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({busy, freeze, done, out_valid, out_last} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got busy/freeze/done/valid/last=%b, expected 00000",
               {busy, freeze, done, out_valid, out_last});
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h, expected 0", out_data);
    end
    checks++;
    if (out_idx !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idx: got %0d, expected 0", out_idx);
    end
    checks++;
    if (ra1 !== '0 || ra2 !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ra: got ra1=%0d ra2=%0d, expected 0 0", ra1, ra2);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_dump;
    int lat, fb, bc;
    pulse_start(5'd0, 5'd31);
    wait_done(1'b0, lat, fb, bc);
    checks++;
    if (lat !== 50) begin
      errors++;
      $display("[TB] FAIL full_latency: got %0d, expected 50", lat);
    end
    checks++;
    if (fb !== 0) begin
      errors++;
      $display("[TB] FAIL full_freeze: got %0d bad cycles, expected 0", fb);
    end
    checks++;
    if (bc !== 49) begin
      errors++;
      $display("[TB] FAIL full_busy_cycles: got %0d, expected 49", bc);
    end
    checks++;
    if (sbq.size() !== 0) begin
      errors++;
      $display("[TB] FAIL full_drain: got %0d beats left, expected 0", sbq.size());
    end
  endtask

  task automatic test_partial;
    int lat, fb, bc;
    pulse_start(5'd5, 5'd7);
    wait_done(1'b0, lat, fb, bc);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("[TB] FAIL partial_latency: got %0d, expected 7", lat);
    end
    checks++;
    if (ra1_log[0] !== 5'd5 || ra2_log[0] !== 5'd6) begin
      errors++;
      $display("[TB] FAIL partial_fetch0: got ra1=%0d ra2=%0d, expected 5 6", ra1_log[0], ra2_log[0]);
    end
    checks++;
    if (ra1_log[3] !== 5'd7 || ra2_log[3] !== 5'd8) begin
      errors++;
      $display("[TB] FAIL partial_fetch1: got ra1=%0d ra2=%0d, expected 7 8", ra1_log[3], ra2_log[3]);
    end
    checks++;
    if (sbq.size() !== 0) begin
      errors++;
      $display("[TB] FAIL partial_drain: got %0d beats left, expected 0", sbq.size());
    end
  endtask

  task automatic test_wrap;
    int lat, fb, bc;
    pulse_start(5'd31, 5'd31);
    wait_done(1'b0, lat, fb, bc);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("[TB] FAIL wrap_latency: got %0d, expected 4", lat);
    end
    checks++;
    if (ra1_log[0] !== 5'd31 || ra2_log[0] !== 5'd0) begin
      errors++;
      $display("[TB] FAIL wrap_fetch: got ra1=%0d ra2=%0d, expected 31 0", ra1_log[0], ra2_log[0]);
    end
    checks++;
    if (sbq.size() !== 0) begin
      errors++;
      $display("[TB] FAIL wrap_drain: got %0d beats left, expected 0", sbq.size());
    end
  endtask

  task automatic test_empty;
    int lat, fb, bc;
    pulse_start(5'd9, 5'd3);
    wait_done(1'b0, lat, fb, bc);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("[TB] FAIL empty_latency: got %0d, expected 2", lat);
    end
    checks++;
    if (bc !== 1) begin
      errors++;
      $display("[TB] FAIL empty_busy_cycles: got %0d, expected 1", bc);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_idle: got busy=%b, expected 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall;
    int lat, fb, bc;
    pulse_start(5'd0, 5'd3);
    wait_done(1'b1, lat, fb, bc);
    checks++;
    if (lat < 0) begin
      errors++;
      $display("[TB] FAIL stall_timeout: got latency %0d, expected done", lat);
    end
    checks++;
    if (fb !== 0) begin
      errors++;
      $display("[TB] FAIL stall_freeze: got %0d bad cycles, expected 0", fb);
    end
    checks++;
    if (sbq.size() !== 0) begin
      errors++;
      $display("[TB] FAIL stall_drain: got %0d beats left, expected 0", sbq.size());
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_idle: got busy=%b, expected 0 (mid-dump start must be ignored)", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    pulse_start(5'd10, 5'd10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    first_reg = 5'd12;
    last_reg  = 5'd12;
    start     = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_done: got done=%b, expected 1", done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_ignored_start: got busy=%b, expected 0", busy);
    end
    checks++;
    if (sbq.size() !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got %0d beats left, expected 0", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat, fb, bc;
    pulse_start(5'd0, 5'd31);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd1) begin
      errors++;
      $display("[TB] FAIL mid_in_send1: got valid=%b idx=%0d, expected 1 1", out_valid, out_idx);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL mid_reset: got valid/busy/done=%b, expected 000", {out_valid, busy, done});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    pulse_start(5'd2, 5'd4);
    wait_done(1'b0, lat, fb, bc);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("[TB] FAIL mid_restart_latency: got %0d, expected 7", lat);
    end
    checks++;
    if (sbq.size() !== 0) begin
      errors++;
      $display("[TB] FAIL mid_restart_drain: got %0d beats left, expected 0", sbq.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'hA5A5_0000 + i;
    test_reset;
    test_full_dump;
    test_partial;
    test_wrap;
    test_empty;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
